// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared state encodings, baud codes and sizing helper for uart_tx_sched
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

  // baud_set codes understood by uart_byte_tx
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rtl/uart_tx_sched_rr_arbiter.sv - combinational round-robin pick, first request after ptr wins
module uart_tx_sched_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  int idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin, frame-locked byte scheduler in front of one uart_byte_tx
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 data_byte,
  output logic                       send_en,
  input  logic                       Tx_Done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = cnt_width(TIMEOUT);
  localparam int GPW = cnt_width(GAP_CYCLES);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WDOG_MAX  = WDW'(TIMEOUT);
  localparam logic [GPW-1:0] GAP_LAST  = GPW'(GAP_CYCLES - 1);
  localparam logic [GPW-1:0] GAP_MAX   = GPW'(GAP_CYCLES);

  tx_state_t          r_state, w_state_next;
  logic               r_lock;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_grant_id;
  logic [7:0]         r_data;
  logic [WDW-1:0]     r_wdog;
  logic [GPW-1:0]     r_gap;

  logic [NUM_REQ-1:0] w_owner_mask;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]     w_gnt_id;
  logic               w_any;
  logic               w_accept;

  assign w_owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
  assign w_cand       = r_lock ? (req_valid & w_owner_mask) : req_valid;

  uart_tx_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req    (w_cand),
    .ptr    (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // The TIMEOUT-th WAIT cycle after send_en is the abort cycle; Tx_Done in that cycle still wins.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    send_en      = 1'b0;
    err          = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready    = w_gnt;
          w_accept     = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        send_en      = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (Tx_Done) begin
          w_state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else if (r_wdog == WDOG_LAST) begin
          err          = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_lock     <= 1'b0;
      r_rr_ptr   <= IDW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_data     <= 8'h00;
      r_wdog     <= '0;
      r_gap      <= '0;
    end else begin
      if (w_accept) begin
        r_data     <= req_data[8*int'(w_gnt_id) +: 8];
        r_grant_id <= w_gnt_id;
        r_lock     <= ~req_last[w_gnt_id];
        if (req_last[w_gnt_id]) r_rr_ptr <= w_gnt_id;
      end
      if (err) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= r_grant_id;
      end
      if (r_state == ST_SEND)                         r_wdog <= '0;
      else if (r_state == ST_WAIT && r_wdog != WDOG_MAX) r_wdog <= r_wdog + 1'b1;
      if (r_state != ST_GAP)                          r_gap <= '0;
      else if (r_gap != GAP_MAX)                      r_gap <= r_gap + 1'b1;
    end
  end

  assign data_byte = r_data;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with requester and uart_byte_tx models
module tb_uart_tx_sched;

  localparam int NUM_REQ    = 2;
  localparam int GAP_CYCLES = 16;
  localparam int TIMEOUT    = 100;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  data_byte;
  logic        send_en;
  logic        Tx_Done;
  logic [0:0]  grant_id;
  logic        busy;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int sends_seen = 0;

  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [8:0] exp_q[$];
  int         tx_delay  = 0;
  bit         tx_inject = 1'b0;

  always #5 Clk = ~Clk;

  uart_tx_sched #(
    .NUM_REQ    (NUM_REQ),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .data_byte (data_byte),
    .send_en   (send_en),
    .Tx_Done   (Tx_Done),
    .grant_id  (grant_id),
    .busy      (busy),
    .err       (err)
  );

  // Requesters: each presents the head of its queue and pops it after a handshake.
  initial begin
    bit hs0, hs1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge Clk);
      hs0 = (req_valid[0] && req_ready[0]);
      hs1 = (req_valid[1] && req_ready[1]);
      @(posedge Clk);
      #1;
      if (hs0 && src_q0.size() > 0) void'(src_q0.pop_front());
      if (hs1 && src_q1.size() > 0) void'(src_q1.pop_front());
      req_valid[0] = (src_q0.size() > 0);
      req_valid[1] = (src_q1.size() > 0);
      if (src_q0.size() > 0) {req_last[0], req_data[7:0]}  = src_q0[0];
      else                   {req_last[0], req_data[7:0]}  = 9'h000;
      if (src_q1.size() > 0) {req_last[1], req_data[15:8]} = src_q1[0];
      else                   {req_last[1], req_data[15:8]} = 9'h000;
    end
  end

  // uart_byte_tx model: Tx_Done tx_delay cycles after send_en (0 = never).
  initial begin
    int cnt;
    cnt = 0;
    Tx_Done = 1'b0;
    forever begin
      @(negedge Clk);
      Tx_Done = 1'b0;
      if (tx_inject) begin
        Tx_Done   = 1'b1;
        tx_inject = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) Tx_Done = 1'b1;
      end
      if (send_en === 1'b1 && tx_delay > 0) cnt = tx_delay;
    end
  end

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge Clk);
      if (send_en === 1'b1) begin
        sends_seen++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_send: got id=%0d byte=%02h, required no send", grant_id, data_byte);
        end else begin
          e = exp_q.pop_front();
          if ({grant_id, data_byte} !== e)
            $display("FAIL sb_byte: got id=%0d byte=%02h, required id=%0d byte=%02h",
                     grant_id, data_byte, e[8], e[7:0]);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_send(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (send_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (exp_q.size() == 0 && src_q0.size() == 0 && src_q1.size() == 0 &&
          busy === 1'b0 && req_valid == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit f;
    bit stray;
    Rst = 1'b1;
    tx_delay = 0;
    repeat (3) tick();
    total_cnt++; if (send_en !== 1'b0) $display("FAIL rst_send_en: got %0b required 0", send_en); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b required 0", busy); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %02b required 00", req_ready); else pass_cnt++;
    total_cnt++; if (data_byte !== 8'h00) $display("FAIL rst_data: got %02h required 00", data_byte); else pass_cnt++;
    total_cnt++; if (err !== 1'b0 || grant_id !== 1'b0) $display("FAIL rst_err_gid: got err=%0b gid=%0d required 0/0", err, grant_id); else pass_cnt++;
    Rst = 1'b0;
    tick();
    src_q1.push_back({1'b1, 8'h3c});
    exp_q.push_back({1'b1, 8'h3c});
    wait_send(20, f);
    total_cnt++; if (f !== 1'b1) $display("FAIL rst_pre_send: got %0b required 1", f); else pass_cnt++;
    repeat (5) tick();
    Rst = 1'b1;
    tick();
    total_cnt++; if (send_en !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_wait: got send_en=%0b busy=%0b required 0/0", send_en, busy); else pass_cnt++;
    total_cnt++; if (grant_id !== 1'b0 || req_ready !== 2'b00) $display("FAIL rst_mid_gid: got gid=%0d ready=%02b required 0/00", grant_id, req_ready); else pass_cnt++;
    Rst = 1'b0;
    tx_inject = 1'b1;
    stray = 1'b0;
    repeat (6) begin
      tick();
      if (busy !== 1'b0 || err !== 1'b0 || send_en !== 1'b0) stray = 1'b1;
    end
    total_cnt++; if (stray !== 1'b0) $display("FAIL rst_done_ignored: got activity=%0b required 0", stray); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int base;
    base = sends_seen;
    tx_delay = 4;
    src_q0.push_back({1'b1, 8'h11}); src_q0.push_back({1'b1, 8'h11});
    src_q1.push_back({1'b1, 8'h22}); src_q1.push_back({1'b1, 8'h22});
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b1, 8'h22});
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b1, 8'h22});
    wait_drain(600, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL rr_drain: got %0b required 1", ok); else pass_cnt++;
    total_cnt++; if (sends_seen - base !== 4) $display("FAIL rr_count: got %0d required 4", sends_seen - base); else pass_cnt++;
  endtask

  task automatic test_single_byte();
    bit seen;
    int n;
    tx_delay = 10;
    src_q0.push_back({1'b1, 8'h7a});
    exp_q.push_back({1'b0, 8'h7a});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (req_valid[0]) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b1 || req_ready !== 2'b01) $display("FAIL single_ready: got valid=%0b ready=%02b required 1/01", seen, req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (send_en !== 1'b1) $display("FAIL single_send_latency: got %0b required 1", send_en); else pass_cnt++;
    total_cnt++; if (data_byte !== 8'h7a) $display("FAIL single_data: got %02h required 7a", data_byte); else pass_cnt++;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total_cnt++; if (n !== 27) $display("FAIL single_busy_len: got %0d required 27", n); else pass_cnt++;
    total_cnt++; if (data_byte !== 8'h7a) $display("FAIL single_data_hold: got %02h required 7a", data_byte); else pass_cnt++;
  endtask

  task automatic test_frame_lock();
    bit f;
    bit viol;
    bit ok;
    tx_delay = 3;
    src_q0.push_back({1'b0, 8'ha1}); src_q0.push_back({1'b0, 8'ha2}); src_q0.push_back({1'b1, 8'ha3});
    exp_q.push_back({1'b0, 8'ha1}); exp_q.push_back({1'b0, 8'ha2}); exp_q.push_back({1'b0, 8'ha3});
    wait_send(20, f);
    total_cnt++; if (f !== 1'b1) $display("FAIL lock_first_send: got %0b required 1", f); else pass_cnt++;
    src_q1.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b1, 8'h55});
    viol = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      if (req_ready[1] === 1'b1 && exp_q.size() > 1) viol = 1'b1;
      if (exp_q.size() == 0 && busy === 1'b0) ok = 1'b1;
    end
    total_cnt++; if (viol !== 1'b0) $display("FAIL lock_ready1_early: got %0b required 0", viol); else pass_cnt++;
    total_cnt++; if (ok !== 1'b1) $display("FAIL lock_drain: got %0b required 1", ok); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    bit f;
    bit ok;
    int n;
    tx_delay = 0;
    src_q0.push_back({1'b0, 8'hb1}); src_q0.push_back({1'b1, 8'hb2});
    src_q1.push_back({1'b1, 8'h66});
    exp_q.push_back({1'b0, 8'hb1}); exp_q.push_back({1'b1, 8'h66}); exp_q.push_back({1'b0, 8'hb2});
    wait_send(20, f);
    total_cnt++; if (f !== 1'b1) $display("FAIL wdog_send: got %0b required 1", f); else pass_cnt++;
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tx_delay = 3;
    total_cnt++; if (n !== 100) $display("FAIL wdog_latency: got %0d required 100", n); else pass_cnt++;
    tick();
    total_cnt++; if (err !== 1'b0) $display("FAIL wdog_err_width: got %0b required 0", err); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL wdog_next_owner: got %02b required 10", req_ready); else pass_cnt++;
    wait_drain(600, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL wdog_drain: got %0b required 1", ok); else pass_cnt++;
  endtask

  task automatic test_done_at_timeout();
    bit f;
    bit err_seen;
    int n;
    tx_delay = TIMEOUT;
    src_q1.push_back({1'b1, 8'hc1});
    exp_q.push_back({1'b1, 8'hc1});
    wait_send(20, f);
    total_cnt++; if (f !== 1'b1) $display("FAIL race_send: got %0b required 1", f); else pass_cnt++;
    n = 0;
    err_seen = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
      if (err === 1'b1) err_seen = 1'b1;
    end
    total_cnt++; if (err_seen !== 1'b0) $display("FAIL race_err: got %0b required 0", err_seen); else pass_cnt++;
    total_cnt++; if (n !== 117) $display("FAIL race_busy_len: got %0d required 117", n); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_byte();
    test_frame_lock();
    test_watchdog();
    test_done_at_timeout();
    total_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d required 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
